// File: rtl/dnpcie_aurora_tx_arbiter.sv
// dnpcie_aurora_tx_arbiter
// Whole-packet arbiter sharing the single 16-bit Aurora TX stream between
// NPORTS AXI4-Stream requesters. Grants never switch mid-packet, forwarding
// is gated by channel_up, packets are cut at MAX_BEATS beats, and the rest
// of a cut or dropped source packet is sunk before the next arbitration.
// PASS is a zero-latency combinational path; the downstream path adapter
// supplies the register stage.
// Build option: DNPCIE_AURORA_ARB_PRIO0_EN gives port 0 strict priority,
// with round-robin among ports 1..NPORTS-1 keyed on the last non-zero grant.

module dnpcie_aurora_tx_arbiter #(
  parameter int NPORTS    = 4,
  parameter int MAX_BEATS = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 channel_up,
  input  logic [16*NPORTS-1:0] s_axis_tdata,
  input  logic [2*NPORTS-1:0]  s_axis_tkeep,
  input  logic [NPORTS-1:0]    s_axis_tvalid,
  input  logic [NPORTS-1:0]    s_axis_tlast,
  output logic [NPORTS-1:0]    s_axis_tready,
  output logic [15:0]          m_axis_tdata,
  output logic [1:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [2:0]           grant,
  output logic                 busy,
  output logic                 trunc_err,
  output logic                 drop_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [15:0] LAST_CNT  = 16'(MAX_BEATS - 1);
  localparam logic [2:0]  GRANT_RST = 3'(NPORTS - 1);

  state_t state, state_nxt;

  // per-port views of the flattened requester buses
  logic [NPORTS-1:0][15:0] data_v;
  logic [NPORTS-1:0][1:0]  keep_v;

  logic [15:0] beat_cnt;
  logic [15:0] sel_data;
  logic [1:0]  sel_keep;
  logic        sel_valid;
  logic        sel_last;
  logic [2:0]  arb_idx;
  logic        arb_any;
  logic        arb_take;
  logic        hs_pass;
  logic        at_limit;

  assign data_v = s_axis_tdata;
  assign keep_v = s_axis_tkeep;

  // Mux out the lines of the granted port
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant == 3'(i)) begin
        sel_data  = data_v[i];
        sel_keep  = keep_v[i];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  // Beat accepted by the core while passing through
  assign hs_pass  = (state == PASS) & sel_valid & m_axis_tready & channel_up;
  // Beat that must carry a forced tlast if the source has not ended yet
  assign at_limit = (beat_cnt == LAST_CNT);
  // A new grant is taken only from IDLE with the link up
  assign arb_take = (state == IDLE) & channel_up & arb_any;

`ifdef DNPCIE_AURORA_ARB_PRIO0_EN
  // last non-zero grant, the round-robin pointer over ports 1..NPORTS-1
  logic [2:0] rr_ptr;

  // Port 0 wins outright; otherwise the nearest valid port after rr_ptr in
  // the ring 1..NPORTS-1. Smaller distances are visited last and so win.
  always_comb begin
    arb_idx = grant;
    arb_any = 1'b0;
    for (int k = NPORTS - 1; k >= 1; k--) begin
      for (int j = 1; j < NPORTS; j++) begin
        if (s_axis_tvalid[j] && ((((int'(rr_ptr) - 1 + k) % (NPORTS - 1)) + 1) == j)) begin
          arb_idx = 3'(j);
          arb_any = 1'b1;
        end
      end
    end
    if (s_axis_tvalid[0]) begin
      arb_idx = 3'd0;
      arb_any = 1'b1;
    end
  end

  // Pointer follows every grant that is not port 0
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      rr_ptr <= GRANT_RST;
    else if (arb_take && (arb_idx != 3'd0))
      rr_ptr <= arb_idx;
  end
`else
  // Nearest valid port searching upward from grant+1 with wrap; smaller
  // distances are visited last and so take precedence.
  always_comb begin
    arb_idx = grant;
    arb_any = 1'b0;
    for (int k = NPORTS; k >= 1; k--) begin
      for (int j = 0; j < NPORTS; j++) begin
        if (s_axis_tvalid[j] && (((int'(grant) + k) % NPORTS) == j)) begin
          arb_idx = 3'(j);
          arb_any = 1'b1;
        end
      end
    end
  end
`endif

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state: whole packets only, flush after a cut or a link drop
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (arb_take)
          state_nxt = PASS;
      end
      PASS: begin
        if (!channel_up)
          state_nxt = FLUSH;
        else if (hs_pass) begin
          if (sel_last)
            state_nxt = IDLE;
          else if (at_limit)
            state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (sel_valid && sel_last)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: pass-through in PASS, sink-only in FLUSH, quiet in IDLE
  always_comb begin
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant == 3'(i)) begin
        case (state)
          PASS:    s_axis_tready[i] = m_axis_tready & channel_up;
          FLUSH:   s_axis_tready[i] = 1'b1;
          default: s_axis_tready[i] = 1'b0;
        endcase
      end
    end
    if (state == PASS) begin
      m_axis_tdata  = sel_data;
      m_axis_tkeep  = sel_keep;
      m_axis_tvalid = sel_valid & channel_up;
      m_axis_tlast  = sel_last | at_limit;
    end
  end

  assign busy = (state != IDLE);

  // Grant register and beat counter for the packet in flight
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant    <= GRANT_RST;
      beat_cnt <= '0;
    end else if (arb_take) begin
      grant    <= arb_idx;
      beat_cnt <= '0;
    end else if (hs_pass) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

  // Error pulses, one cycle after the truncating beat or the link drop
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      trunc_err <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      trunc_err <= hs_pass & at_limit & ~sel_last;
      drop_err  <= (state == PASS) & ~channel_up;
    end
  end

endmodule

// File: tb/tb_dnpcie_aurora_tx_arbiter.sv
// Bench for dnpcie_aurora_tx_arbiter: per-port source queues drive packets,
// a packet-level model predicts every output each cycle, and directed
// scenarios add literal expectations on the forwarded beat stream.
module tb_dnpcie_aurora_tx_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 5;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             channel_up = 1'b0;
  logic [16*N-1:0]  s_tdata = '0;
  logic [2*N-1:0]   s_tkeep = '0;
  logic [N-1:0]     s_tvalid = '0;
  logic [N-1:0]     s_tlast = '0;
  logic [N-1:0]     s_tready;
  logic [15:0]      m_tdata;
  logic [1:0]       m_tkeep;
  logic             m_tvalid, m_tlast;
  logic             m_tready = 1'b0;
  logic [2:0]       grant;
  logic             busy, trunc_err, drop_err;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  dnpcie_aurora_tx_arbiter #(.NPORTS(N), .MAX_BEATS(MAXB)) dut (
    .aclk(aclk), .aresetn(aresetn), .channel_up(channel_up),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .grant(grant), .busy(busy), .trunc_err(trunc_err), .drop_err(drop_err)
  );

  typedef struct { logic [15:0] d; logic [1:0] k; logic l; } beat_t;
  typedef struct { logic [15:0] d; logic [1:0] k; logic l; int cyc; } obeat_t;

  beat_t  srcq [N][$];
  obeat_t olog [$];
  logic [N-1:0] hs_seen = '0;
  int cyc = 0;
  int trunc_cnt = 0, drop_cnt = 0, bp_viol = 0;
  bit bp_mon = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- packet-level model ----------------
  int owner = -1, sent = 0, lastg = N - 1, ptr = N - 1;
  bit sinking = 1'b0, tp = 1'b0, dp = 1'b0;
  int nx_owner, nx_sent, nx_lastg, nx_ptr;
  bit nx_sinking, nx_tp, nx_dp;
  logic [N-1:0] e_rdy;
  logic e_vld, e_lst, ov, ol;
  logic [15:0] e_d, od;
  logic [1:0] e_k, ok;
  int pk;

  // Winner of an arbitration: smallest ring distance after the pointer
  function automatic int pick_port(input logic [N-1:0] v, input int p_in);
    int best, bd, d;
    best = -1;
    bd = 1000;
`ifdef DNPCIE_AURORA_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int p = 1; p < N; p++)
      if (v[p]) begin
        d = (p - p_in - 1 + 2 * (N - 1)) % (N - 1);
        if (d < bd) begin bd = d; best = p; end
      end
`else
    for (int p = 0; p < N; p++)
      if (v[p]) begin
        d = (p - p_in - 1 + 2 * N) % N;
        if (d < bd) begin bd = d; best = p; end
      end
`endif
    return best;
  endfunction

  // Compare every cycle on the falling edge, then plan the model's next state
  always @(negedge aclk) begin
    ov = 1'b0; ol = 1'b0; od = '0; ok = '0;
    for (int p = 0; p < N; p++)
      if (p == owner) begin
        ov = s_tvalid[p]; ol = s_tlast[p]; od = s_tdata[16*p +: 16]; ok = s_tkeep[2*p +: 2];
      end
    e_rdy = '0; e_vld = 1'b0; e_lst = 1'b0; e_d = '0; e_k = '0;
    for (int p = 0; p < N; p++)
      if (p == owner) e_rdy[p] = sinking ? 1'b1 : (m_tready & channel_up);
    if (owner >= 0 && !sinking) begin
      e_vld = ov & channel_up;
      e_d = od; e_k = ok;
      e_lst = ol | (sent == MAXB - 1);
    end
    chk("grant", 32'(grant), 32'(lastg));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("trunc_err", 32'(trunc_err), 32'(tp));
    chk("drop_err", 32'(drop_err), 32'(dp));
    chk("m_tvalid", 32'(m_tvalid), 32'(e_vld));
    chk("s_tready", 32'(s_tready), 32'(e_rdy));
    if (owner >= 0 && !sinking) begin
      chk("m_tdata", 32'(m_tdata), 32'(e_d));
      chk("m_tkeep", 32'(m_tkeep), 32'(e_k));
      chk("m_tlast", 32'(m_tlast), 32'(e_lst));
    end

    nx_owner = owner; nx_sent = sent; nx_lastg = lastg; nx_ptr = ptr;
    nx_sinking = sinking; nx_tp = 1'b0; nx_dp = 1'b0;
    if (owner < 0) begin
      if (channel_up && (s_tvalid != '0)) begin
`ifdef DNPCIE_AURORA_ARB_PRIO0_EN
        pk = pick_port(s_tvalid, ptr);
`else
        pk = pick_port(s_tvalid, lastg);
`endif
        nx_owner = pk; nx_lastg = pk; nx_sent = 0;
        if (pk != 0) nx_ptr = pk;
      end
    end else if (!sinking) begin
      if (!channel_up) begin
        nx_dp = 1'b1; nx_sinking = 1'b1;
      end else if (ov && m_tready) begin
        nx_sent = sent + 1;
        if (ol) nx_owner = -1;
        else if (sent == MAXB - 1) begin nx_tp = 1'b1; nx_sinking = 1'b1; end
      end
    end else if (ov && ol) begin
      nx_owner = -1; nx_sinking = 1'b0;
    end

    hs_seen = s_tvalid & s_tready;
    if (m_tvalid && m_tready) olog.push_back('{m_tdata, m_tkeep, m_tlast, cyc});
    if (trunc_err) trunc_cnt++;
    if (drop_err) drop_cnt++;
    if (bp_mon && (((s_tready & 4'b1011) != '0) || (busy && (s_tready[2] != m_tready)))) bp_viol++;
  end

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      owner <= -1; sent <= 0; lastg <= N - 1; ptr <= N - 1;
      sinking <= 1'b0; tp <= 1'b0; dp <= 1'b0;
    end else begin
      owner <= nx_owner; sent <= nx_sent; lastg <= nx_lastg; ptr <= nx_ptr;
      sinking <= nx_sinking; tp <= nx_tp; dp <= nx_dp;
    end
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // ---------------- source driver ----------------
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i] = 1'b1;
        s_tdata[16*i +: 16] = srcq[i][0].d;
        s_tkeep[2*i +: 2] = srcq[i][0].k;
        s_tlast[i] = srcq[i][0].l;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tdata[16*i +: 16] = '0;
        s_tkeep[2*i +: 2] = '0;
        s_tlast[i] = 1'b0;
      end
    end
  endtask

  initial forever begin
    @(posedge aclk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs_seen[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    drive();
  end

  // Beat b of packet id from port p: data {p, id, b}, keep 11 on odd beats
  task automatic push_pkt(input int p, input int id, input int nb);
    beat_t b;
    for (int i = 1; i <= nb; i++) begin
      b.d = {4'(p), 4'(id), 8'(i)};
      b.k = (i % 2 == 1) ? 2'b11 : 2'b10;
      b.l = (i == nb);
      srcq[p].push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string nm, input int budget, input bit toggle);
    int n;
    n = 0;
    do begin
      tick();
      if (toggle) m_tready = ~m_tready;
      n++;
    end while ((!queues_empty() || busy) && n < budget);
    chk({nm, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  task automatic wait_log(input string nm, input int target, input int budget);
    int n;
    n = 0;
    while (olog.size() < target && n < budget) begin tick(); n++; end
    chk({nm, "_timeout"}, 32'(n >= budget), 32'd0);
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({nm, "_m_tlast"}, 32'(m_tlast), 32'd0);
    chk({nm, "_m_tdata"}, 32'(m_tdata), 32'd0);
    chk({nm, "_m_tkeep"}, 32'(m_tkeep), 32'd0);
    chk({nm, "_s_tready"}, 32'(s_tready), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_errs"}, 32'({trunc_err, drop_err}), 32'd0);
    chk({nm, "_grant"}, 32'(grant), 32'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  int base, tc0, dc0, p, id;
  int ord [8];
  int ord6 [5];
  int seen [N];
  logic [15:0] ed;

  initial begin
    repeat (2) tick();
    rst_chk("reset");

    // Round-robin: every port offers two 3-beat packets back to back
    aresetn = 1'b1; channel_up = 1'b1; m_tready = 1'b1;
    for (int i = 0; i < N; i++) begin push_pkt(i, 0, 3); push_pkt(i, 1, 3); end
    drive();
`ifdef DNPCIE_AURORA_ARB_PRIO0_EN
    ord = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    wait_idle("rr", 200, 1'b0);
    chk("rr_count", 32'(olog.size()), 32'd24);
    for (int i = 0; i < N; i++) seen[i] = 0;
    for (int j = 0; j < 24 && j < olog.size(); j++) begin
      p = ord[j / 3];
      ed = {4'(p), 4'(seen[p]), 8'(j % 3 + 1)};
      chk($sformatf("rr_data%0d", j), 32'(olog[j].d), 32'(ed));
      chk($sformatf("rr_last%0d", j), 32'(olog[j].l), 32'(j % 3 == 2));
      chk($sformatf("rr_cyc%0d", j), 32'(olog[j].cyc - olog[0].cyc), 32'((j / 3) * 4 + j % 3));
      if (j % 3 == 2) seen[p]++;
    end

    // Backpressure: port 2, 5 beats ending exactly at the beat limit
    base = olog.size(); tc0 = trunc_cnt;
    bp_mon = 1'b1;
    push_pkt(2, 2, 5);
    drive();
    wait_idle("bp", 100, 1'b1);
    bp_mon = 1'b0;
    m_tready = 1'b1;
    chk("bp_count", 32'(olog.size() - base), 32'd5);
    for (int j = 0; j < 5 && base + j < olog.size(); j++) begin
      chk($sformatf("bp_data%0d", j), 32'(olog[base + j].d), 32'h2201 + 32'(j));
      chk($sformatf("bp_last%0d", j), 32'(olog[base + j].l), 32'(j == 4));
    end
    chk("bp_ready_mirror", 32'(bp_viol), 32'd0);
    chk("bp_no_trunc", 32'(trunc_cnt - tc0), 32'd0);

    // Truncation: port 1 offers 7 beats, only 5 are forwarded
    base = olog.size(); tc0 = trunc_cnt;
    push_pkt(1, 3, 7);
    drive();
    wait_idle("trunc", 100, 1'b0);
    chk("trunc_count", 32'(olog.size() - base), 32'd5);
    for (int j = 0; j < 5 && base + j < olog.size(); j++) begin
      chk($sformatf("trunc_data%0d", j), 32'(olog[base + j].d), 32'h1301 + 32'(j));
      chk($sformatf("trunc_last%0d", j), 32'(olog[base + j].l), 32'(j == 4));
    end
    if (olog.size() >= base + 5) chk("trunc_keep5", 32'(olog[base + 4].k), 32'h3);
    chk("trunc_pulses", 32'(trunc_cnt - tc0), 32'd1);

    // Channel drop after beat 2 of a 6-beat packet from port 3
    base = olog.size(); dc0 = drop_cnt;
    push_pkt(3, 4, 6);
    drive();
    wait_log("drop", base + 2, 50);
    channel_up = 1'b0;
    push_pkt(0, 5, 2);
    drive();
    @(negedge aclk);
    chk("drop_same_cycle_tvalid", 32'(m_tvalid), 32'd0);
    repeat (10) tick();
    chk("drop_flushed", 32'(srcq[3].size()), 32'd0);
    chk("drop_no_grant_busy", 32'(busy), 32'd0);
    chk("drop_no_grant_idx", 32'(grant), 32'd3);
    chk("drop_no_output", 32'(olog.size() - base), 32'd2);
    chk("drop_pulses", 32'(drop_cnt - dc0), 32'd1);
    channel_up = 1'b1;
    wait_idle("drop_resume", 50, 1'b0);
    chk("drop_resume_count", 32'(olog.size() - base), 32'd4);
    if (olog.size() >= base + 3) chk("drop_resume_data", 32'(olog[base + 2].d), 32'h0501);

    // Reset in the middle of beat 3 of a port 2 packet
    base = olog.size();
    push_pkt(2, 6, 6);
    drive();
    wait_log("rst", base + 2, 50);
    #1;
    aresetn = 1'b0;
    #1;
    rst_chk("rst_mid");
    tick();
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    tick();
    push_pkt(0, 7, 1);
    push_pkt(2, 8, 1);
    drive();
    tick();
    aresetn = 1'b1;
    base = olog.size();
    wait_idle("rst_resume", 50, 1'b0);
    chk("rst_resume_count", 32'(olog.size() - base), 32'd2);
    if (olog.size() >= base + 2) begin
      chk("rst_first_grant", 32'(olog[base].d), 32'h0701);
      chk("rst_second_grant", 32'(olog[base + 1].d), 32'h2801);
    end

    // Port 0 and port 2 compete continuously
    base = olog.size();
    push_pkt(0, 9, 2); push_pkt(0, 10, 2); push_pkt(0, 11, 2);
    push_pkt(2, 12, 2); push_pkt(2, 13, 2);
    drive();
    wait_idle("prio", 200, 1'b0);
`ifdef DNPCIE_AURORA_ARB_PRIO0_EN
    ord6 = '{32'h0901, 32'h0A01, 32'h0B01, 32'h2C01, 32'h2D01};
`else
    ord6 = '{32'h0901, 32'h2C01, 32'h0A01, 32'h2D01, 32'h0B01};
`endif
    chk("prio_count", 32'(olog.size() - base), 32'd10);
    for (int k = 0; k < 5 && base + 2 * k < olog.size(); k++)
      chk($sformatf("prio_pkt%0d", k), 32'(olog[base + 2 * k].d), 32'(ord6[k]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dnpcie_aurora_tx_arbiter.md
# dnpcie_aurora_tx_arbiter

Packet-level arbiter that shares the single 16-bit Aurora transmit path (the `s_axis_tx_*` input of `dnpcie_aurora_core`) between `NPORTS` upstream AXI4-Stream requesters. It is clocked by the link `user_clk`.
- Grants are round-robin and whole-packet; a grant is never switched mid-packet.
- Packets are gated by `channel_up`.
- Packets are truncated at `MAX_BEATS` beats.
- After a channel drop or a truncation, the remainder of the source packet is flushed.

## Interface
Parameters:
- `NPORTS`, 4, number of requesters; legal range 2..8.
- `MAX_BEATS`, 1024, maximum 16-bit beats per forwarded packet; legal range 2..65535.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `aclk`  in  1  clock; connect to Aurora `user_clk`.
  - `aresetn`  in  1  asynchronous active-low reset.
- `channel_up`  in  1  Aurora channel status; treat as synchronous to `aclk`.
- Requester side, flattened. Port i owns `tdata[16*i:16*i+15]` and `tkeep[2*i:2*i+1]`, big-endian numbering as in the core.
  - `s_axis_tdata`  in  16*NPORTS  requester data.
  - `s_axis_tkeep`  in  2*NPORTS  requester byte enables; passed through, not interpreted.
  - `s_axis_tvalid`  in  NPORTS  bit i = port i.
  - `s_axis_tlast`  in  NPORTS  bit i = port i.
  - `s_axis_tready`  out  NPORTS  bit i = port i.
- Core side:
  - `m_axis_tdata`  out  16  data to `s_axis_tx_tdata`.
  - `m_axis_tkeep`  out  2  byte enables to `s_axis_tx_tkeep`.
  - `m_axis_tvalid`  out  1.
  - `m_axis_tlast`  out  1.
  - `m_axis_tready`  in  1.
- Status:
  - `grant`  out  3  index of the current or last granted port.
  - `busy`  out  1  high when the state is PASS or FLUSH.
  - `trunc_err`  out  1  one-cycle pulse on a forced-`tlast` beat.
  - `drop_err`  out  1  one-cycle pulse when `channel_up` falls during PASS.

## Operation
State machine: IDLE, PASS, FLUSH.

- **Reset values:**
  - state = IDLE, `grant` = NPORTS-1 (so port 0 wins first), beat counter = 0.
  - All `s_axis_tready` = 0.
  - `m_axis_tvalid`, `m_axis_tlast`, `busy`, `trunc_err`, `drop_err` = 0.
  - `m_axis_tdata` and `m_axis_tkeep` = 0.
- **IDLE:**
  - All `s_axis_tready` = 0 and `m_axis_tvalid` = 0.
  - If `channel_up` = 1 and any `s_axis_tvalid` is high:
    - select the first valid port searching from (`grant`+1) mod NPORTS upward, with wrap;
    - register it into `grant`; clear the beat counter; go to PASS.
- **PASS:** combinational pass-through of port g = `grant`.
  - `m_axis_tdata` = data[g], `m_axis_tkeep` = keep[g].
  - `m_axis_tvalid` = `s_axis_tvalid[g]` & `channel_up`.
  - `s_axis_tready[g]` = `m_axis_tready` & `channel_up`; all other ready bits are 0.
  - Each handshake increments the 16-bit beat counter.
  - `m_axis_tlast` = `s_axis_tlast[g]` | (counter == MAX_BEATS-1).
  - On a handshake with `s_axis_tlast[g]`: go to IDLE.
  - On a handshake at counter == MAX_BEATS-1 without a source `tlast`: pulse `trunc_err` and go to FLUSH. If source `tlast` coincides with that beat, it is a normal end: go to IDLE, no error.
  - If `channel_up` = 0 in PASS: pulse `drop_err` and go to FLUSH.
- **FLUSH:**
  - `s_axis_tready[g]` = 1 and `m_axis_tvalid` = 0. Beats are discarded regardless of `channel_up`.
  - On a handshake with `s_axis_tlast[g]`: go to IDLE.
- A port that deasserts `tvalid` mid-packet keeps the grant; there is no timeout.
- `tkeep` is forwarded unmodified, including on truncated beats.

## Timing
- Arbitration costs 1 cycle: the grant is registered in IDLE and the first beat can pass on the following cycle.
- There is a minimum of 1 idle cycle between packets, because end-of-packet always returns through IDLE.
- PASS has zero latency. Two combinational paths exist:
  - `m_axis_tready` → `s_axis_tready`;
  - `s_axis_tvalid`/`s_axis_tdata` → `m_axis_*`.
- The downstream `dnpcie_aurora_tx_path_adapter` provides the register stage.
- `trunc_err` and `drop_err` are registered: they are asserted the cycle after the triggering event, for exactly 1 cycle.
- `channel_up` falling and a source `tlast` handshake in the same PASS cycle cannot both complete: with `channel_up` = 0 there is no handshake, so the FLUSH path is taken.
- Asynchronous reset mid-packet: all outputs take their reset values immediately; the partially sent packet is abandoned.

## Configuration
- Macro: `DNPCIE_AURORA_ARB_PRIO0_EN`.
- Defined: in IDLE, port 0 wins whenever `s_axis_tvalid[0]` = 1. Otherwise, round-robin applies over ports 1..NPORTS-1, using the last non-zero grant as the pointer.
- Undefined: pure round-robin over all ports, as described in Operation.

## Test plan
- **Round-robin order:** NPORTS=4; all ports continuously offer 3-beat packets, `m_axis_tready`=1, `channel_up`=1. Required:
  - grant order 0,1,2,3,0;
  - each packet occupies 3 output beats followed by 1 bubble cycle.
- **Backpressure:** port 2 sends a 5-beat packet; `m_axis_tready` toggles 1,0,1,0. Required:
  - `s_axis_tready[2]` mirrors `m_axis_tready` exactly;
  - all 5 beats arrive in order;
  - the other ports' `tready` stays 0.
- **Truncation:** MAX_BEATS=4; port 1 sends a 6-beat packet. Required:
  - output is 4 beats with `m_axis_tlast` on beat 4;
  - `trunc_err` pulses once;
  - beats 5–6 are sunk with `m_axis_tvalid`=0, then the state returns to IDLE.
- **Channel drop:** `channel_up` falls after beat 2 of a 6-beat packet from port 3. Required:
  - `m_axis_tvalid` goes to 0 in the same cycle;
  - `drop_err` pulses once;
  - the remaining beats are flushed;
  - no new grant is issued until `channel_up` = 1.
- **Priority build:** with `DNPCIE_AURORA_ARB_PRIO0_EN` defined, port 0 and port 2 request continuously. Required: grants alternate only when port 0 is idle; port 0 wins every arbitration in which it is valid.
- **Reset mid-packet:** assert `aresetn`=0 during beat 3 of a packet, then release. Required:
  - all outputs are 0 immediately;
  - the first post-reset grant goes to port 0.
